// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch with redirect flush and a one-entry skid buffer in front of decode.
// Latency: an issued address reaches out_* 2 cycles later; a redirect target reaches out_* 3 cycles after redirect_valid.
// Backpressure: out_ready low holds out_*, parks the in-flight response in the skid entry and freezes issue until space frees.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    logic [63:0] pc_q;
    logic [63:0] req_pc_q;
    logic        req_valid_q;

    // The output stage has three states encoded by two flags:
    // EMPTY (!out_valid), FULL (out_valid, !skid_valid), FULL_SKID (out_valid, skid_valid).
    logic        skid_valid;
    logic [63:0] skid_pc;
    logic [31:0] skid_instr;

    logic stall;
    logic resp_valid;
    logic issue;

    // Redirect targets are word aligned; the low address bits are ignored.
    logic redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Memory address comes straight from the PC register.
    assign imem_pc = pc_q;

    // Handshake terms; a response landing in a redirect cycle is discarded.
    always_comb begin
        stall      = out_valid && !out_ready;
        resp_valid = req_valid_q && !redirect_valid;
        // Only issue when the response returning next cycle is guaranteed a home.
        issue      = !redirect_valid && (!skid_valid || !stall) && !(stall && resp_valid);
    end

    // Fetch PC and in-flight request tracking; redirect overrides sequential issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= 64'h0;
            req_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q        <= {redirect_pc[63:2], 2'b00};
            req_valid_q <= 1'b0;
        end else if (issue) begin
            pc_q        <= pc_q + 64'd4;
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
        end else begin
            req_valid_q <= 1'b0;
        end
    end

    // Output register and skid entry: drain skid first, then the memory response; park responses while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= 64'h0;
            out_instr  <= 32'h0;
            skid_valid <= 1'b0;
            skid_pc    <= 64'h0;
            skid_instr <= 32'h0;
        end else if (redirect_valid) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!stall) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_pc     <= skid_pc;
                out_instr  <= skid_instr;
                skid_valid <= 1'b0;
            end else if (resp_valid) begin
                out_valid  <= 1'b1;
                out_pc     <= req_pc_q;
                out_instr  <= imem_instr;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (resp_valid) begin
            skid_valid <= 1'b1;
            skid_pc    <= req_pc_q;
            skid_instr <= imem_instr;
        end
    end

endmodule
